// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling with a
// runtime bit length, one-cycle strobes for good bytes, framing errors and overruns.
//   state     | meaning
//   IDLE      | line idle, waiting for a low level
//   START     | timing to the middle of the start bit
//   BIT0-BIT7 | sampling data bits, LSB first
//   STOP      | sampling the stop bit
//   WAIT_HIGH | framing error seen, waiting for the line to return high
module uart_rx #(
  parameter int BIT_LENGTH_WIDTH = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        rxd,
  input  logic [BIT_LENGTH_WIDTH-1:0] bit_length,
  output logic [7:0]                  data,
  output logic                        write_enable,
  input  logic                        fifo_full,
  output logic                        framing_error,
  output logic                        overrun,
  output logic                        busy
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    START     = 4'd1,
    BIT0      = 4'd2,
    BIT1      = 4'd3,
    BIT2      = 4'd4,
    BIT3      = 4'd5,
    BIT4      = 4'd6,
    BIT5      = 4'd7,
    BIT6      = 4'd8,
    BIT7      = 4'd9,
    STOP      = 4'd10,
    WAIT_HIGH = 4'd11
  } state_t;

  state_t                      state;
  logic [BIT_LENGTH_WIDTH-1:0] timer;
  logic [BIT_LENGTH_WIDTH-1:0] bl;
  logic [7:0]                  shift;
  logic                        rxd_m;
  logic                        rxd_s;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      timer         <= '0;
      bl            <= '0;
      shift         <= 8'h00;
      data          <= 8'h00;
      write_enable  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      write_enable  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state <= START;
            timer <= '0;
            bl    <= bit_length;
          end
        end
        START: begin
          if (timer == (bl >> 1)) begin
            timer <= '0;
            state <= rxd_s ? IDLE : BIT0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        BIT0, BIT1, BIT2, BIT3, BIT4, BIT5, BIT6, BIT7: begin
          if (timer == bl) begin
            shift <= {rxd_s, shift[7:1]};
            timer <= '0;
            // Encoding is ordered so BIT7 + 1 lands on STOP.
            state <= state_t'(state + 4'd1);
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          if (timer == bl) begin
            timer <= '0;
            if (!rxd_s) begin
              framing_error <= 1'b1;
              state         <= WAIT_HIGH;
            end else begin
              if (fifo_full) begin
                overrun <= 1'b1;
              end else begin
                data         <= shift;
                write_enable <= 1'b1;
              end
              state <= IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rxd_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1 frames at 16 clocks/bit with hand-computed
// strobe timing, glitch, framing, overrun and mid-frame reset scenarios.
module tb_uart_rx;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        rxd = 1'b1;
  logic        fifo_full = 1'b0;
  logic [15:0] bit_length = 16'd15;
  logic [7:0]  data;
  logic        write_enable;
  logic        framing_error;
  logic        overrun;
  logic        busy;

  uart_rx #(.BIT_LENGTH_WIDTH(16)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .rxd           (rxd),
    .bit_length    (bit_length),
    .data          (data),
    .write_enable  (write_enable),
    .fifo_full     (fifo_full),
    .framing_error (framing_error),
    .overrun       (overrun),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0] we_data[$];
  int         we_cyc[$];
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         excl = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  always @(negedge clock) begin
    if (write_enable) begin
      we_data.push_back(data);
      we_cyc.push_back(cyc);
    end
    if (framing_error) fe_cnt++;
    if (overrun) ov_cnt++;
    if ((int'(write_enable) + int'(framing_error) + int'(overrun)) > 1) excl++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qd(input int i);
    return (i < we_data.size()) ? {24'h0, we_data[i]} : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] qc(input int i);
    return (i < we_cyc.size()) ? we_cyc[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic clear_log();
    we_data.delete();
    we_cyc.delete();
  endtask

  // Drives one frame starting just after the current posedge (edge 0),
  // 16 clocks per bit; optionally resets mid-frame or changes bit_length.
  task automatic send_byte(input logic [7:0] b, input logic stop, input int abort_at,
                           input int blchg_at, output int t0);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    t0 = 0;
    for (int e = 0; e < 160; e++) begin
      #1;
      if (e == 0) t0 = cyc;
      if (e % 16 == 0) rxd = frame[e/16];
      if (blchg_at != 0 && e == blchg_at) bit_length = 16'd7;
      @(posedge clock);
      if (abort_at != 0 && e + 1 == abort_at) begin
        #1;
        reset_n = 1'b0;
        rxd = 1'b1;
        return;
      end
    end
  endtask

  int t0, ta, tb2, tc, fe0, ov0;

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_data", data, 8'h00);
    check("rst_we", write_enable, 1'b0);
    check("rst_fe", framing_error, 1'b0);
    check("rst_ov", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    repeat (5) @(posedge clock);

    // 1: single byte, strobe latency
    clear_log();
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_byte(8'hA5, 1'b1, 0, 0, t0);
    repeat (20) @(posedge clock);
    #1;
    check("t1_count", we_data.size(), 1);
    check("t1_latency", qc(0) - t0, 155);
    check("t1_data", qd(0), 8'hA5);
    check("t1_fe", fe_cnt - fe0, 0);
    check("t1_ov", ov_cnt - ov0, 0);
    check("t1_busy", busy, 1'b0);

    // 2: back-to-back frames
    @(posedge clock);
    clear_log();
    send_byte(8'h00, 1'b1, 0, 0, ta);
    send_byte(8'hFF, 1'b1, 0, 0, tb2);
    send_byte(8'h3C, 1'b1, 0, 0, tc);
    repeat (20) @(posedge clock);
    #1;
    check("t2_count", we_data.size(), 3);
    check("t2_lat0", qc(0) - ta, 155);
    check("t2_gap01", qc(1) - qc(0), 160);
    check("t2_gap12", qc(2) - qc(1), 160);
    check("t2_d0", qd(0), 8'h00);
    check("t2_d1", qd(1), 8'hFF);
    check("t2_d2", qd(2), 8'h3C);

    // 3: 4-clock low glitch rejected
    @(posedge clock);
    clear_log();
    #1 rxd = 1'b0;
    repeat (4) @(posedge clock);
    #1 rxd = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("t3_busy_mid", busy, 1'b1);
    repeat (6) @(posedge clock);
    #1;
    check("t3_busy_c12", busy, 1'b0);
    repeat (20) @(posedge clock);
    #1;
    check("t3_nostrobe", we_data.size(), 0);
    @(posedge clock);
    send_byte(8'h5A, 1'b1, 0, 0, t0);
    repeat (20) @(posedge clock);
    #1;
    check("t3_count", we_data.size(), 1);
    check("t3_data", qd(0), 8'h5A);

    // 4: framing error followed by a held-low break
    @(posedge clock);
    clear_log();
    fe0 = fe_cnt;
    send_byte(8'h81, 1'b0, 0, 0, t0);
    repeat (320) @(posedge clock);
    #1;
    check("t4_busy_break", busy, 1'b1);
    repeat (304) @(posedge clock);
    #1 rxd = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("t4_busy_until_high", busy, 1'b1);
    @(posedge clock);
    #1;
    check("t4_busy_released", busy, 1'b0);
    check("t4_fe_count", fe_cnt - fe0, 1);
    check("t4_nostrobe", we_data.size(), 0);
    repeat (20) @(posedge clock);
    send_byte(8'h42, 1'b1, 0, 0, t0);
    repeat (20) @(posedge clock);
    #1;
    check("t4_count", we_data.size(), 1);
    check("t4_data", qd(0), 8'h42);

    // 5: overrun while fifo_full
    @(posedge clock);
    clear_log();
    ov0 = ov_cnt; fe0 = fe_cnt;
    fifo_full = 1'b1;
    send_byte(8'h77, 1'b1, 0, 0, t0);
    repeat (20) @(posedge clock);
    #1;
    check("t5_ov_count", ov_cnt - ov0, 1);
    check("t5_nostrobe", we_data.size(), 0);
    check("t5_data_held", data, 8'h42);
    check("t5_fe", fe_cnt - fe0, 0);
    fifo_full = 1'b0;
    @(posedge clock);
    send_byte(8'h78, 1'b1, 0, 0, t0);
    repeat (20) @(posedge clock);
    #1;
    check("t5_count", we_data.size(), 1);
    check("t5_data", qd(0), 8'h78);

    // 6a: reset asserted at the BIT4 sample point
    @(posedge clock);
    clear_log();
    send_byte(8'hE7, 1'b1, 91, 0, t0);
    #1;
    check("t6_rst_data", data, 8'h00);
    check("t6_rst_we", write_enable, 1'b0);
    check("t6_rst_fe", framing_error, 1'b0);
    check("t6_rst_ov", overrun, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    repeat (10) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (200) @(posedge clock);
    #1;
    check("t6_nostrobe", we_data.size(), 0);
    @(posedge clock);
    send_byte(8'hC3, 1'b1, 0, 0, t0);
    repeat (20) @(posedge clock);
    #1;
    check("t6_count", we_data.size(), 1);
    check("t6_data", qd(0), 8'hC3);

    // 6b: bit_length changed mid-frame does not affect the current frame
    @(posedge clock);
    clear_log();
    send_byte(8'h96, 1'b1, 0, 40, t0);
    repeat (20) @(posedge clock);
    #1;
    check("t6b_count", we_data.size(), 1);
    check("t6b_latency", qc(0) - t0, 155);
    check("t6b_data", qd(0), 8'h96);
    bit_length = 16'd15;

    check("pulse_exclusive", excl, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver, the receive-side counterpart of the existing transmitter.
- Samples serial line `rxd`, reassembles bytes LSB-first and pushes each good byte into an rx FIFO with a single-cycle write strobe.
- Reports framing errors and overruns as one-cycle pulses.
- Shares the runtime `bit_length` convention with the transmitter: clock periods per bit minus 1.

Parameters:
- BIT_LENGTH_WIDTH, 16, width of the `bit_length` input and of the internal bit timer.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- rxd  input  1  serial line, asynchronous to `clock`, idles high.
- bit_length  input  BIT_LENGTH_WIDTH  clock periods per bit minus 1; minimum legal value 3.
- data  output  8  received byte; valid while `write_enable` is high.
- write_enable  output  1  rx FIFO write strobe, one cycle per accepted byte.
- fifo_full  input  1  rx FIFO cannot accept a write this cycle.
- framing_error  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: good byte dropped because `fifo_full` was high.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, bit timer=0, shift register=0.
  - data=8'h00; write_enable, framing_error, overrun, busy all 0.
  - Both synchronizer flops=1.
- Input sync: `rxd` passes through 2 flip-flops; the FSM sees only `rxd_s`, i.e. 2 clocks of latency.
- `bit_length` is latched into `bl` on start detection; changes mid-frame have no effect until the next frame.
- FSM states: IDLE, START, BIT0..BIT7, STOP, WAIT_HIGH.
- IDLE:
  - `rxd_s`==0 -> START, timer=0.
- START:
  - Timer increments each clock.
  - When timer==(bl>>1) (mid start bit), sample `rxd_s`.
  - Sample 1 -> glitch/false start: IDLE, no outputs.
  - Sample 0 -> BIT0, timer=0.
- BITn:
  - Timer increments each clock.
  - When timer==bl: shift `rxd_s` into shift register MSB (right-shift, so the first bit ends in bit 0), timer=0, go to next state.
  - BIT7 -> STOP.
- STOP: at timer==bl, sample `rxd_s`.
  - Sample 1, `fifo_full`=0: data<=shift, write_enable<=1 for one cycle; -> IDLE.
  - Sample 1, `fifo_full`=1: overrun<=1 for one cycle; data unchanged, no write; -> IDLE.
  - Sample 0: framing_error<=1 for one cycle; no write; -> WAIT_HIGH.
- WAIT_HIGH:
  - Stays until `rxd_s`==1, then -> IDLE.
  - A held-low break line produces exactly one framing_error and no spurious frames.
- Pulse rules:
  - write_enable, framing_error and overrun are mutually exclusive.
  - Each is high for exactly one clock per frame.
  - `data` holds its value until the next accepted byte.
- Latency, in clocks after `rxd_s` first reads 0:
  - Start sample at (bl>>1)+1.
  - Each data bit 16 apart at bl=15.
  - Stop sample at (bl>>1)+1+9*(bl+1).
  - write_enable is high the cycle after the stop sample.
- Back-to-back frames: a new start bit may fall immediately after the stop-bit sample point. IDLE re-arms on the next clock with no dead time beyond 1 cycle.
- Timer width: BIT_LENGTH_WIDTH, compare-equal only; it never wraps within a legal frame.
- reset_n asserted mid-frame: immediate return to reset values; the partial byte is discarded and no strobe is issued.

Test Plan:
1. bl=15, send 8'hA5 as 8N1 with 16 clocks/bit, line changing between edges 0 and 1 -> write_enable high exactly one cycle, at edge 155 (3 sync/detect + 8 + 144), data=8'hA5, no error pulses.
2. bl=15, send 8'h00, 8'hFF, 8'h3C back-to-back with no idle gap -> three write_enable pulses 160 clocks apart, data 8'h00, 8'hFF, 8'h3C in order.
3. bl=15, 4-clock low glitch on rxd -> no strobe, FSM returns to IDLE (busy low) by clock 12; a valid 8'h5A sent afterwards is received correctly.
4. bl=15, frame 8'h81 with stop bit low, line held low 40 bit-times then high -> exactly one framing_error pulse, no write_enable, busy stays high until rxd_s returns high; next frame 8'h42 received OK.
5. bl=15, fifo_full=1 during frame 8'h77 -> overrun pulse, no write_enable, data keeps its previous value; drop fifo_full and send 8'h78 -> write_enable with data=8'h78.
6. bl=15, assert reset_n low at the BIT4 sample, release 10 clocks later with rxd high -> all outputs 0 at once, no strobe; next frame 8'hC3 received correctly. Repeat with bit_length changed mid-frame from 15 to 7 -> the current byte is still decoded at 16 clocks/bit.
